// File: rtl/udp_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_fifo_pkg
// Description : Shared defaults, sample type and sizing helper for the UDP
//               packet FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_fifo_pkg;

  localparam int DATA_WIDTH = 48;
  localparam int ADDR_WIDTH = 8;
  localparam int PKT_LEN    = 245;

  typedef logic [DATA_WIDTH-1:0] sample_t;

  // Bits needed to count 0..value-1; never less than one so a 1-word packet still has an index.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sdp_ram
// Description : Simple dual-port RAM, one write port and one registered read
//               port; no reset so it maps onto block memory.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/udp_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : udp_packet_fifo
// Description : Sample FIFO with UDP packet framing and dropped-write stats.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_packet_fifo #(
  parameter int DATA_WIDTH    = udp_fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH    = udp_fifo_pkg::ADDR_WIDTH,
  parameter int PKT_LEN       = udp_fifo_pkg::PKT_LEN,
  parameter int OVF_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     rd_sop,
  output logic                     rd_eop,
  output logic [ADDR_WIDTH:0]      fill_level,
  output logic                     empty,
  output logic                     full,
  output logic                     pkt_ready,
  output logic                     overflow,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count,
  input  logic                     ovf_clear
);

  import udp_fifo_pkg::*;

  localparam int                  c_IDX_W    = clog2(PKT_LEN);
  localparam logic [ADDR_WIDTH:0] c_DEPTH    = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] c_PKT_LEN  = (ADDR_WIDTH+1)'(PKT_LEN);
  localparam logic [c_IDX_W-1:0]  c_PKT_LAST = c_IDX_W'(PKT_LEN-1);

  logic [ADDR_WIDTH-1:0]    r_wr_ptr;
  logic [ADDR_WIDTH-1:0]    r_rd_ptr;
  logic [ADDR_WIDTH:0]      r_fill;
  logic [c_IDX_W-1:0]       r_pkt_idx;
  logic                     r_empty;
  logic                     r_full;
  logic                     r_pkt_ready;
  logic                     r_rd_valid;
  logic                     r_rd_sop;
  logic                     r_rd_eop;
  logic                     r_rd_seen;
  logic                     r_overflow;
  logic [OVF_CNT_WIDTH-1:0] r_ovf_count;

  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_drop;
  logic [ADDR_WIDTH:0]      w_fill_next;
  logic [DATA_WIDTH-1:0]    w_ram_q;

  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;
  assign w_drop   = wr_en && r_full;

  always_comb begin
    w_fill_next = r_fill;
    if (w_wr_acc && !w_rd_acc) begin
      w_fill_next = r_fill + (ADDR_WIDTH+1)'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_fill_next = r_fill - (ADDR_WIDTH+1)'(1);
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (wr_data),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rd_ptr),
    .rd_data (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_pkt_ready <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_fill      <= w_fill_next;
      r_empty     <= (w_fill_next == '0);
      r_full      <= (w_fill_next == c_DEPTH);
      r_pkt_ready <= (w_fill_next >= c_PKT_LEN);
    end
  end

  // The RAM output register has no reset; r_rd_seen masks it until the first read after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_idx  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_sop   <= 1'b0;
      r_rd_eop   <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_pkt_idx <= (r_pkt_idx == c_PKT_LAST) ? '0 : r_pkt_idx + c_IDX_W'(1);
        r_rd_seen <= 1'b1;
      end
      r_rd_valid <= w_rd_acc;
      r_rd_sop   <= w_rd_acc && (r_pkt_idx == '0);
      r_rd_eop   <= w_rd_acc && (r_pkt_idx == c_PKT_LAST);
    end
  end

  // A clear coinciding with a drop leaves exactly that one drop recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else if (ovf_clear) begin
      r_overflow  <= w_drop;
      r_ovf_count <= w_drop ? OVF_CNT_WIDTH'(1) : '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_ovf_count != '1) begin
        r_ovf_count <= r_ovf_count + OVF_CNT_WIDTH'(1);
      end
    end
  end

  assign rd_data    = r_rd_seen ? w_ram_q : '0;
  assign rd_valid   = r_rd_valid;
  assign rd_sop     = r_rd_sop;
  assign rd_eop     = r_rd_eop;
  assign fill_level = r_fill;
  assign empty      = r_empty;
  assign full       = r_full;
  assign pkt_ready  = r_pkt_ready;
  assign overflow   = r_overflow;
  assign ovf_count  = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_udp_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_packet_fifo
// Description : Self-checking bench for udp_packet_fifo (8-deep, 5-word packets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_packet_fifo;

  localparam int c_DW    = 48;
  localparam int c_AW    = 3;
  localparam int c_DEPTH = 8;
  localparam int c_PKT   = 5;
  localparam int c_OW    = 3;
  localparam int c_OMAX  = 7;

  typedef udp_fifo_pkg::sample_t sample_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  sample_t           wr_data = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic              ovf_clear = 1'b0;
  sample_t           rd_data;
  logic              rd_valid, rd_sop, rd_eop;
  logic [c_AW:0]     fill_level;
  logic              empty, full, pkt_ready, overflow;
  logic [c_OW-1:0]   ovf_count;

  udp_packet_fifo #(
    .DATA_WIDTH    (c_DW),
    .ADDR_WIDTH    (c_AW),
    .PKT_LEN       (c_PKT),
    .OVF_CNT_WIDTH (c_OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_sop     (rd_sop),
    .rd_eop     (rd_eop),
    .fill_level (fill_level),
    .empty      (empty),
    .full       (full),
    .pkt_ready  (pkt_ready),
    .overflow   (overflow),
    .ovf_count  (ovf_count),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a queue, framing from a running word count.
  sample_t q[$];
  int      m_words_read;
  logic    m_valid, m_sop, m_eop, m_ovf;
  sample_t m_data;
  int      m_cnt;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_words_read = 0;
    m_valid = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_ovf = 1'b0;
    m_data = '0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(input logic wr, input sample_t d, input logic rd, input logic clr);
    int  n;
    logic drop;
    n    = q.size();
    drop = wr && (n == c_DEPTH);
    if (rd && n != 0) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
      m_sop   = (m_words_read % c_PKT) == 0;
      m_eop   = (m_words_read % c_PKT) == c_PKT - 1;
      m_words_read++;
    end else begin
      m_valid = 1'b0; m_sop = 1'b0; m_eop = 1'b0;
    end
    if (wr && n != c_DEPTH) q.push_back(d);
    if (clr) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      m_cnt = (m_cnt + 1 > c_OMAX) ? c_OMAX : m_cnt + 1;
    end
  endfunction

  function automatic void compare_all();
    check("fill_level", fill_level, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == c_DEPTH);
    check("pkt_ready", pkt_ready, q.size() >= c_PKT);
    check("rd_valid", rd_valid, m_valid);
    check("rd_sop", rd_sop, m_sop);
    check("rd_eop", rd_eop, m_eop);
    check("rd_data", rd_data, m_data);
    check("overflow", overflow, m_ovf);
    check("ovf_count", ovf_count, m_cnt);
  endfunction

  task automatic step(input logic wr, input sample_t d, input logic rd, input logic clr);
    wr_en = wr; wr_data = d; rd_en = rd; ovf_clear = clr;
    @(posedge clk);
    model_step(wr, d, rd, clr);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic    wr;
    sample_t wdata;
    logic    rd;
    int      exp_fill;
    logic    exp_empty;
    logic    exp_pkt;
    logic    exp_valid;
    logic    exp_sop;
    logic    exp_eop;
    sample_t exp_data;
  } vec_t;

  function automatic vec_t mk(input logic wr, input sample_t wd, input logic rd, input int f,
                              input logic e, input logic p, input logic v, input logic s,
                              input logic eo, input sample_t dat);
    vec_t r;
    r.wr = wr; r.wdata = wd; r.rd = rd; r.exp_fill = f; r.exp_empty = e; r.exp_pkt = p;
    r.exp_valid = v; r.exp_sop = s; r.exp_eop = eo; r.exp_data = dat;
    return r;
  endfunction

  vec_t vecs[12];

  initial begin
    //             wr    data   rd   fill empty pkt  valid sop  eop  rd_data
    vecs[0]  = mk(1'b1, 48'h1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    vecs[1]  = mk(1'b1, 48'h2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    vecs[2]  = mk(1'b1, 48'h3, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    vecs[3]  = mk(1'b1, 48'h4, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    vecs[4]  = mk(1'b1, 48'h5, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
    vecs[5]  = mk(1'b0, 48'h0, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h1);
    vecs[6]  = mk(1'b0, 48'h0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h2);
    vecs[7]  = mk(1'b0, 48'h0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h3);
    vecs[8]  = mk(1'b0, 48'h0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h4);
    vecs[9]  = mk(1'b0, 48'h0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 48'h5);
    vecs[10] = mk(1'b0, 48'h0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h5);
    vecs[11] = mk(1'b1, 48'h77, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h5);

    model_reset();
    #23;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed fill, packet read, idle hold and read+write on empty.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].wr, vecs[i].wdata, vecs[i].rd, 1'b0);
      check("vec_fill", fill_level, vecs[i].exp_fill);
      check("vec_empty", empty, vecs[i].exp_empty);
      check("vec_pkt_ready", pkt_ready, vecs[i].exp_pkt);
      check("vec_valid", rd_valid, vecs[i].exp_valid);
      check("vec_sop", rd_sop, vecs[i].exp_sop);
      check("vec_eop", rd_eop, vecs[i].exp_eop);
      check("vec_data", rd_data, vecs[i].exp_data);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Wrap and full.
    for (int i = 0; i < 8; i++) step(1'b1, sample_t'(48'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, sample_t'(48'hA8 + i), 1'b0, 1'b0);
    check("wrap_full", full, 1'b1);
    check("wrap_fill", fill_level, 8);

    // Overflow, clear-with-drop and saturation.
    for (int i = 0; i < 4; i++) step(1'b1, 48'hDEAD, 1'b0, 1'b0);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_count4", ovf_count, 4);
    step(1'b1, 48'hBEEF, 1'b0, 1'b1);
    check("ovf_clr_drop", ovf_count, 1);
    check("ovf_clr_flag", overflow, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 48'hDEAD, 1'b1 && (i == 8), 1'b0);
    check("ovf_sat", ovf_count, c_OMAX);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 1'b0);

    // Simultaneous read and write at fill 4.
    for (int i = 0; i < 4; i++) step(1'b1, sample_t'(48'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, sample_t'(48'hD0 + i), 1'b1, 1'b0);
    check("simul_fill", fill_level, 4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a packet.
    for (int i = 0; i < 5; i++) step(1'b1, sample_t'(48'hE0 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_valid", rd_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, sample_t'(48'hF0 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("rst_next_sop", rd_sop, 1'b1);
    check("rst_next_data", rd_data, 48'hF0);

    // Randomised traffic with alternating write/read bias.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 100; i++) begin
        int      wp;
        logic    w, rr, c;
        sample_t d;
        wp = (r % 2 == 0) ? 70 : 30;
        w  = $urandom_range(0, 99) < wp;
        rr = $urandom_range(0, 99) < (100 - wp);
        c  = $urandom_range(0, 31) == 0;
        d  = sample_t'({$urandom(), $urandom()});
        step(w, d, rr, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
